id_hazard_scoreboard: RTL and testbench

Register-dependency scoreboard for the decode stage of the five-stage ARM pipeline. It tracks every in-flight write to the architectural register file (R0–R14) between issue out of decode and write-back. It produces the `hazard` stall consumed by the decode stage, the fetch PC register and the IF/ID pipeline register. Per-register pending counters replace a stage-by-stage comparator chain, so stall decisions stay correct for any pipeline depth up to `MAX_INFLIGHT`.

---
 rtl/id_hazard_scoreboard.sv | 106 ++++++++++
 tb/tb_id_hazard_scoreboard.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage register-dependency scoreboard: per-register pending-write counters
// drive the decode stall and track in-flight writes between issue and write-back.
module id_hazard_scoreboard #(
  parameter int unsigned ADDRESS_LEN_REG_FILE = 4,
  parameter int unsigned SIZE_REG_FILE        = 15,
  parameter int unsigned MAX_INFLIGHT         = 3,
  parameter int unsigned WB_BYPASS            = 1,
  parameter int unsigned CNT_LEN              = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] src1,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] src2,
  input  logic                            two_src,
  input  logic                            id_valid,
  input  logic                            id_wb_en,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] id_dest,
  input  logic                            flush,
  input  logic                            wb_wb_en,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] wb_dest,
  output logic                            hazard,
  output logic [SIZE_REG_FILE-1:0]        pending,
  output logic [CNT_LEN-1:0]              stall_cycles,
  output logic                            sb_error
);

  localparam int unsigned AW   = ADDRESS_LEN_REG_FILE;
  localparam int unsigned NREG = SIZE_REG_FILE;
  localparam int unsigned CW   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [NREG-1:0][CW-1:0] cnt;
  logic [NREG-1:0][CW-1:0] cnt_nxt;
  logic [NREG-1:0] nonzero, at_max, retire_hit, dest_hit;
  logic [NREG-1:0] src1_hit, src2_hit, busy_vec, issue_vec, pending_nxt;
  logic            busy1, busy2, full, issue_ok, err_set;

  // Per-register decode of addresses; R15 never matches because i < NREG.
  always_comb begin
    nonzero    = '0;
    at_max     = '0;
    retire_hit = '0;
    dest_hit   = '0;
    src1_hit   = '0;
    src2_hit   = '0;
    busy_vec   = '0;
    for (int i = 0; i < NREG; i++) begin
      nonzero[i]    = cnt[i] != '0;
      at_max[i]     = cnt[i] == CNT_MAX;
      retire_hit[i] = wb_wb_en && (wb_dest == AW'(i));
      dest_hit[i]   = id_wb_en && (id_dest == AW'(i));
      src1_hit[i]   = src1 == AW'(i);
      src2_hit[i]   = src2 == AW'(i);
      // Last outstanding write retiring now is forwarded by the register file.
      busy_vec[i]   = nonzero[i] &&
                      !((WB_BYPASS != 0) && retire_hit[i] && (cnt[i] == CNT_ONE));
    end
  end

  assign busy1     = |(src1_hit & busy_vec);
  assign busy2     = |(src2_hit & busy_vec);
  assign full      = |(dest_hit & at_max & ~retire_hit);
  assign hazard    = id_valid && !flush && (busy1 || (two_src && busy2) || full);
  assign issue_ok  = id_valid && !flush && !hazard;
  assign issue_vec = dest_hit & {NREG{issue_ok}};

  // Counter next state; issue and retire to the same register cancel out.
  always_comb begin
    cnt_nxt     = cnt;
    err_set     = 1'b0;
    pending_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      case ({issue_vec[i], retire_hit[i]})
        2'b10: begin
          if (at_max[i]) err_set = 1'b1;
          else           cnt_nxt[i] = cnt[i] + CNT_ONE;
        end
        2'b01: begin
          if (!nonzero[i]) err_set = 1'b1;
          else             cnt_nxt[i] = cnt[i] - CNT_ONE;
        end
        2'b11: begin
          if (!nonzero[i]) err_set = 1'b1;
        end
        default: ;
      endcase
      pending_nxt[i] = cnt_nxt[i] != '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      pending      <= '0;
      stall_cycles <= '0;
      sb_error     <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      pending  <= pending_nxt;
      sb_error <= sb_error | err_set;
      if (hazard && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_LEN'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Bench for id_hazard_scoreboard: directed pipeline scenarios followed by random
// traffic, all checked against a count-per-register reference model.
module tb_id_hazard_scoreboard;

  localparam int unsigned NREG = 15;
  localparam int unsigned MAXI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src1, src2, id_dest, wb_dest;
  logic        two_src, id_valid, id_wb_en, flush, wb_wb_en;
  logic        hazard;
  logic [14:0] pending;
  logic [31:0] stall_cycles;
  logic        sb_error;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cnt_m [NREG];
  logic [31:0] stall_m;
  bit          err_m;
  bit          exp_h;
  logic        h_seen;
  logic [31:0] stall_snap;

  always #5 clk = ~clk;

  id_hazard_scoreboard dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .id_valid(id_valid), .id_wb_en(id_wb_en), .id_dest(id_dest), .flush(flush),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .hazard(hazard), .pending(pending),
    .stall_cycles(stall_cycles), .sb_error(sb_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_busy(input logic [3:0] a);
    int r = int'(a);
    if (r >= int'(NREG)) return 1'b0;
    if (cnt_m[r] == 0) return 1'b0;
    if (wb_wb_en && wb_dest == a && cnt_m[r] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_hazard();
    bit full = 1'b0;
    int d = int'(id_dest);
    if (id_wb_en && d < int'(NREG))
      full = (cnt_m[d] == int'(MAXI)) && !(wb_wb_en && wb_dest == id_dest);
    return id_valid && !flush && (m_busy(src1) || (two_src && m_busy(src2)) || full);
  endfunction

  function automatic logic [14:0] m_pending();
    logic [14:0] p = '0;
    for (int i = 0; i < int'(NREG); i++) p[i] = (cnt_m[i] != 0);
    return p;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(NREG); i++) cnt_m[i] = 0;
    stall_m = '0;
    err_m   = 1'b0;
  endtask

  // Apply one clock edge to the model using the rules in plain counting terms.
  task automatic m_update();
    int  d = int'(id_dest);
    int  w = int'(wb_dest);
    bit  iss = id_valid && !flush && !exp_h && id_wb_en && d < int'(NREG);
    bit  ret = wb_wb_en && w < int'(NREG);
    if (ret && cnt_m[w] == 0) err_m = 1'b1;
    if (!(iss && ret && d == w)) begin
      if (iss) begin
        if (cnt_m[d] == int'(MAXI)) err_m = 1'b1;
        else cnt_m[d]++;
      end
      if (ret && cnt_m[w] > 0) cnt_m[w]--;
    end
    if (exp_h && stall_m != 32'hFFFF_FFFF) stall_m++;
  endtask

  task automatic run_cycle(input string tag);
    #1;
    exp_h  = m_hazard();
    h_seen = hazard;
    check({tag, ":hazard"}, 64'(hazard), 64'(exp_h));
    @(posedge clk);
    m_update();
    #1;
    check({tag, ":pending"}, 64'(pending), 64'(m_pending()));
    check({tag, ":stall"}, 64'(stall_cycles), 64'(stall_m));
    check({tag, ":err"}, 64'(sb_error), 64'(err_m));
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic we, input logic [3:0] d);
    id_valid = v; src1 = s1; src2 = s2; two_src = two; id_wb_en = we; id_dest = d;
  endtask

  task automatic set_wb(input logic en, input logic [3:0] d);
    wb_wb_en = en; wb_dest = d;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0);
    set_wb(1'b0, 4'd0);
    flush = 1'b0;
  endtask

  // Reset pulled between edges must clear tracking before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    m_reset();
    check({tag, ":hazard"}, 64'(hazard), 64'(0));
    check({tag, ":pending"}, 64'(pending), 64'(0));
    check({tag, ":stall"}, 64'(stall_cycles), 64'(0));
    check({tag, ":err"}, 64'(sb_error), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    idle();
  endtask

  function automatic logic [3:0] pick_wb_dest();
    int busy_q[$];
    for (int i = 0; i < int'(NREG); i++) if (cnt_m[i] != 0) busy_q.push_back(i);
    if (busy_q.size() == 0 || $urandom_range(15) == 0) return 4'($urandom_range(15));
    return 4'(busy_q[$urandom_range(busy_q.size() - 1)]);
  endfunction

  initial begin
    rst = 1'b0;
    idle();
    m_reset();
    #12;
    check("reset:hazard", 64'(hazard), 64'(0));
    check("reset:pending", 64'(pending), 64'(0));
    check("reset:stall", 64'(stall_cycles), 64'(0));
    check("reset:err", 64'(sb_error), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // RAW on R1 through EXE and MEM, released in the WB cycle by the bypass.
    set_id(1, 4'd0, 4'd0, 0, 1, 4'd1); run_cycle("t1_add");
    set_id(1, 4'd1, 4'd3, 1, 1, 4'd2); run_cycle("t1_exe");
    check("t1_exe_stall", 64'(h_seen), 64'(1));
    run_cycle("t1_mem");
    check("t1_mem_stall", 64'(h_seen), 64'(1));
    set_wb(1, 4'd1); run_cycle("t1_wb");
    check("t1_wb_release", 64'(h_seen), 64'(0));
    check("t1_stall_total", 64'(stall_cycles), 64'(2));
    check("t1_r1_clear", 64'(pending[1]), 64'(0));
    idle(); set_wb(1, 4'd2); run_cycle("t1_drain");

    // Fill R4 to the limit, then a same-cycle retire frees a slot.
    idle();
    for (int k = 0; k < 3; k++) begin
      set_id(1, 4'd0, 4'd0, 0, 1, 4'd4); run_cycle("t2_fill");
    end
    run_cycle("t2_full");
    check("t2_full_stall", 64'(h_seen), 64'(1));
    set_wb(1, 4'd4); run_cycle("t2_swap");
    check("t2_swap_nostall", 64'(h_seen), 64'(0));
    check("t2_r4_pending", 64'(pending[4]), 64'(1));
    idle();
    for (int k = 0; k < 3; k++) begin
      set_wb(1, 4'd4); run_cycle("t2_drain");
    end

    // Issue+retire on R5 cancels; retire to empty R6 is an error.
    idle(); set_id(1, 4'd0, 4'd0, 0, 1, 4'd5); run_cycle("t3_issue");
    set_wb(1, 4'd5); run_cycle("t3_both");
    check("t3_r5_pending", 64'(pending[5]), 64'(1));
    idle(); set_wb(1, 4'd6); run_cycle("t3_empty");
    check("t3_err", 64'(sb_error), 64'(1));
    set_wb(1, 4'd5); run_cycle("t3_drain");

    // Flush hides both the stall and the issue.
    idle(); set_id(1, 4'd0, 4'd0, 0, 1, 4'd7); run_cycle("t4_issue");
    stall_snap = stall_cycles;
    set_id(1, 4'd7, 4'd0, 0, 1, 4'd8); flush = 1'b1; run_cycle("t4_flush");
    check("t4_nostall", 64'(h_seen), 64'(0));
    check("t4_r8", 64'(pending[8]), 64'(0));
    check("t4_stall_hold", 64'(stall_cycles), 64'(stall_snap));
    idle(); set_wb(1, 4'd7); run_cycle("t4_drain");

    // R15 is never tracked; an unused src2 never stalls.
    idle(); set_id(1, 4'd15, 4'd0, 0, 1, 4'd15); run_cycle("t5_pc");
    check("t5_pc_nostall", 64'(h_seen), 64'(0));
    check("t5_pc_pending", 64'(pending), 64'(0));
    set_id(1, 4'd0, 4'd0, 0, 1, 4'd9); run_cycle("t5_r9");
    set_id(1, 4'd0, 4'd9, 0, 0, 4'd0); run_cycle("t5_one_src");
    check("t5_one_src_nostall", 64'(h_seen), 64'(0));
    idle(); set_wb(1, 4'd9); run_cycle("t5_drain");

    // Async reset with R1-R3 pending and a stall in progress.
    idle();
    for (int k = 1; k <= 3; k++) begin
      set_id(1, 4'd0, 4'd0, 0, 1, 4'(k)); run_cycle("t6_pend");
    end
    set_id(1, 4'd1, 4'd0, 0, 0, 4'd0); run_cycle("t6_stall");
    check("t6_pending_set", 64'(pending[3:1]), 64'(3'b111));
    async_reset("t6_rst");

    // Random traffic with an occasional asynchronous reset.
    for (int k = 0; k < 1500; k++) begin
      id_valid = ($urandom_range(9) < 8);
      flush    = ($urandom_range(9) == 0);
      src1     = 4'($urandom_range(15));
      src2     = 4'($urandom_range(15));
      two_src  = 1'($urandom_range(1));
      id_wb_en = ($urandom_range(9) < 7);
      id_dest  = 4'($urandom_range(15));
      wb_wb_en = 1'($urandom_range(1));
      wb_dest  = pick_wb_dest();
      run_cycle("rnd");
      if (k % 400 == 399) async_reset("rnd_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
